// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | uart_fifo_bridge: RX/TX byte FIFOs around the uart core, sticky overrun/line     |
// | error flags. Optional hardware echo path when UART_FIFO_BRIDGE_ECHO_EN is defined.|
// | Revision: 1.0                                                                    |
// +----------------------------------------------------------------------------------+
module uart_fifo_bridge #(
  parameter int RX_ADDR_WIDTH = 4,
  parameter int TX_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     u_received,
  input  logic [7:0]               u_rx_byte,
  input  logic                     u_error,
  input  logic                     u_is_transmitting,
  output logic                     u_transmit,
  output logic [7:0]               u_tx_byte,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_read,
  output logic [RX_ADDR_WIDTH:0]   rx_count,
  input  logic [7:0]               tx_data,
  input  logic                     tx_write,
  output logic                     tx_ready,
  output logic                     tx_busy,
  output logic                     overrun,
  output logic                     line_err,
`ifdef UART_FIFO_BRIDGE_ECHO_EN
  input  logic                     echo,
`endif
  input  logic                     clr_flags
);

  localparam int RX_DEPTH = 1 << RX_ADDR_WIDTH;
  localparam int TX_DEPTH = 1 << TX_ADDR_WIDTH;
  localparam logic [RX_ADDR_WIDTH:0] RX_FULL_CNT = (RX_ADDR_WIDTH+1)'(RX_DEPTH);
  localparam logic [TX_ADDR_WIDTH:0] TX_FULL_CNT = (TX_ADDR_WIDTH+1)'(TX_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               rx_hold_q, rx_hold_d;
  logic                     rx_pend_q, rx_pend_d;
  logic [RX_ADDR_WIDTH-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RX_ADDR_WIDTH:0]   rx_count_q, rx_count_d;
  logic [TX_ADDR_WIDTH-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TX_ADDR_WIDTH:0]   tx_count_q, tx_count_d;
  logic [7:0]               u_tx_byte_q, u_tx_byte_d;
  logic                     overrun_q, overrun_d, line_err_q, line_err_d;
  logic [7:0]               rx_mem_q [RX_DEPTH];
  logic [7:0]               tx_mem_q [TX_DEPTH];

  logic       rx_full, rx_pop, rx_wr, rx_drop;
  logic       tx_full, tx_push, tx_pop, echo_push;
  logic [7:0] tx_push_byte;

  assign rx_full = (rx_count_q == RX_FULL_CNT);
  assign rx_pop  = rx_read & rx_valid;
  // A pop in the write cycle frees a slot, so a full FIFO still accepts the byte.
  assign rx_wr   = rx_pend_q & (~rx_full | rx_pop);
  assign rx_drop = rx_pend_q & rx_full & ~rx_pop;

`ifdef UART_FIFO_BRIDGE_ECHO_EN
  assign echo_push = rx_wr & echo;
`else
  assign echo_push = 1'b0;
`endif

  assign tx_full      = (tx_count_q == TX_FULL_CNT);
  assign tx_ready     = ~tx_full & ~echo_push;
  assign tx_push      = (echo_push & ~tx_full) | (tx_write & tx_ready);
  assign tx_push_byte = echo_push ? rx_hold_q : tx_data;

  assign rx_valid  = (rx_count_q != '0);
  assign rx_count  = rx_count_q;
  assign rx_data   = rx_mem_q[rx_rptr_q];
  assign tx_busy   = (tx_count_q != '0) | (state_q != ST_IDLE);
  assign u_tx_byte = u_tx_byte_q;
  assign overrun   = overrun_q;
  assign line_err  = line_err_q;

  always_comb begin
    rx_pend_d  = u_received & ~u_error;
    rx_hold_d  = u_received ? u_rx_byte : rx_hold_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_count_d = rx_count_q;
    if (rx_wr)  rx_wptr_d = rx_wptr_q + RX_ADDR_WIDTH'(1);
    if (rx_pop) rx_rptr_d = rx_rptr_q + RX_ADDR_WIDTH'(1);
    case ({rx_wr, rx_pop})
      2'b10:   rx_count_d = rx_count_q + (RX_ADDR_WIDTH+1)'(1);
      2'b01:   rx_count_d = rx_count_q - (RX_ADDR_WIDTH+1)'(1);
      default: rx_count_d = rx_count_q;
    endcase
    // Set events take priority over a simultaneous clear.
    overrun_d  = rx_drop | (overrun_q & ~clr_flags);
    line_err_d = u_error | (line_err_q & ~clr_flags);
  end

  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_count_d = tx_count_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + TX_ADDR_WIDTH'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_ADDR_WIDTH'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + (TX_ADDR_WIDTH+1)'(1);
      2'b01:   tx_count_d = tx_count_q - (TX_ADDR_WIDTH+1)'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    u_tx_byte_d = u_tx_byte_q;
    u_transmit  = 1'b0;
    tx_pop      = 1'b0;
    case (state_q)
      ST_IDLE:      if (tx_count_q != '0) state_d = ST_LOAD;
      ST_LOAD: begin
        u_tx_byte_d = tx_mem_q[tx_rptr_q];
        tx_pop      = 1'b1;
        state_d     = ST_START;
      end
      ST_START: begin
        u_transmit = 1'b1;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: if (u_is_transmitting)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!u_is_transmitting) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rx_hold_q   <= 8'h00;
      rx_pend_q   <= 1'b0;
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_count_q  <= '0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_count_q  <= '0;
      u_tx_byte_q <= 8'h00;
      overrun_q   <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_hold_q   <= rx_hold_d;
      rx_pend_q   <= rx_pend_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_count_q  <= rx_count_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_count_q  <= tx_count_d;
      u_tx_byte_q <= u_tx_byte_d;
      overrun_q   <= overrun_d;
      line_err_q  <= line_err_d;
    end
  end

  // Storage arrays carry no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (rx_wr)   rx_mem_q[rx_wptr_q] <= rx_hold_q;
    if (tx_push) tx_mem_q[tx_wptr_q] <= tx_push_byte;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// tb_uart_fifo_bridge: directed self-checking bench with a simple uart transmitter model.
`timescale 1ns/1ps
module tb_uart_fifo_bridge;

  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       u_received = 1'b0;
  logic [7:0] u_rx_byte = 8'h00;
  logic       u_error = 1'b0;
  logic       u_is_transmitting = 1'b0;
  logic       rx_read = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_write = 1'b0;
  logic       clr_flags = 1'b0;
`ifdef UART_FIFO_BRIDGE_ECHO_EN
  logic       echo = 1'b0;
`endif
  logic       u_transmit;
  logic [7:0] u_tx_byte;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       tx_ready;
  logic       tx_busy;
  logic       overrun;
  logic       line_err;

  int n_assert = 0;
  int n_fail   = 0;

  uart_fifo_bridge #(.RX_ADDR_WIDTH(4), .TX_ADDR_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .u_received(u_received), .u_rx_byte(u_rx_byte), .u_error(u_error),
    .u_is_transmitting(u_is_transmitting), .u_transmit(u_transmit), .u_tx_byte(u_tx_byte),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read), .rx_count(rx_count),
    .tx_data(tx_data), .tx_write(tx_write), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .overrun(overrun), .line_err(line_err),
`ifdef UART_FIFO_BRIDGE_ECHO_EN
    .echo(echo),
`endif
    .clr_flags(clr_flags)
  );

  initial forever #5 clk = ~clk;

  // uart transmitter model: busy for FRAME cycles after each start strobe
  int unsigned strobes = 0, overlap = 0, wide = 0, busy_left = 0;
  logic        prev_tx = 1'b0;
  logic [7:0]  tx_log [$];

  always @(posedge clk) begin
    prev_tx <= u_transmit;
    if (u_transmit && prev_tx) wide <= wide + 1;
    if (u_transmit && !prev_tx) begin
      if (u_is_transmitting) overlap <= overlap + 1;
      strobes <= strobes + 1;
      tx_log.push_back(u_tx_byte);
      busy_left <= FRAME;
      u_is_transmitting <= 1'b1;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) u_is_transmitting <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    u_rx_byte  = b;
    u_received = 1'b1;
    step();
    u_received = 1'b0;
  endtask

  task automatic pop_rx();
    rx_read = 1'b1;
    step();
    rx_read = 1'b0;
  endtask

  task automatic wait_tx_idle(input int unsigned want_strobes);
    for (int k = 0; k < 400; k++) begin
      if (strobes == want_strobes && !tx_busy && !u_is_transmitting) break;
      step();
    end
  endtask

  initial begin
    int unsigned s0;
    logic [7:0] expb;

    step(2);
    // reset values
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_u_transmit", u_transmit, 0);
    chk("rst_u_tx_byte", u_tx_byte, 8'h00);
    chk("rst_overrun", overrun, 0);
    chk("rst_line_err", line_err, 0);
    reset_n = 1'b1;
    step(2);

    // 1: three RX bytes, 2-cycle latency, FWFT reads in order
    send_rx(8'h41);
    chk("t1_latency_1cyc", rx_valid, 0);
    step();
    chk("t1_latency_2cyc", rx_valid, 1);
    step(3);
    send_rx(8'h42);
    step(3);
    send_rx(8'h43);
    step(3);
    chk("t1_count", rx_count, 3);
    chk("t1_head", rx_data, 8'h41);
    for (int i = 0; i < 3; i++) begin
      expb = 8'h41 + 8'(i);
      chk("t1_read", rx_data, expb);
      pop_rx();
    end
    chk("t1_empty", rx_valid, 0);
    chk("t1_count0", rx_count, 0);

    // 2: 17 bytes into 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      send_rx(8'h10 + 8'(i));
      step();
    end
    step(2);
    chk("t2_count", rx_count, 16);
    chk("t2_overrun", overrun, 1);
    chk("t2_line_err", line_err, 0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t2_clr_overrun", overrun, 0);

    // 3: full FIFO, write coincides with pop
    send_rx(8'hEE);
    rx_read = 1'b1;
    step();
    rx_read = 1'b0;
    chk("t3_count", rx_count, 16);
    chk("t3_overrun", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      expb = (i < 15) ? 8'h11 + 8'(i) : 8'hEE;
      chk("t3_drain", rx_data, expb);
      pop_rx();
    end
    chk("t3_empty", rx_valid, 0);

    // line error: no byte written, sticky, set wins over clear
    u_error = 1'b1;
    send_rx(8'h99);
    u_error = 1'b0;
    step(2);
    chk("le_set", line_err, 1);
    chk("le_no_write", rx_count, 0);
    clr_flags = 1'b1;
    u_error   = 1'b1;
    step();
    clr_flags = 1'b0;
    u_error   = 1'b0;
    chk("le_set_wins", line_err, 1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("le_cleared", line_err, 0);

    // 4: two back-to-back TX writes
    s0 = strobes;
    tx_data  = 8'h55;
    tx_write = 1'b1;
    step();
    tx_data  = 8'hAA;
    step();
    tx_write = 1'b0;
    chk("t4_busy", tx_busy, 1);
    wait_tx_idle(s0 + 2);
    chk("t4_strobes", strobes - s0, 2);
    chk("t4_byte0", tx_log.size() > 0 ? tx_log[0] : 8'hXX, 8'h55);
    chk("t4_byte1", tx_log.size() > 1 ? tx_log[1] : 8'hXX, 8'hAA);
    chk("t4_overlap", overlap, 0);
    chk("t4_wide", wide, 0);
    chk("t4_idle", tx_busy, 0);

    // 5: async reset in WAIT_DONE with 5 bytes still queued
    s0 = strobes;
    tx_write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'hC0 + 8'(i);
      step();
    end
    tx_write = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (strobes != s0) break;
      step();
    end
    step(3);
    chk("t5_midframe", u_is_transmitting, 1);
    send_rx(8'h5A);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", tx_busy, 0);
    chk("t5_rst_ready", tx_ready, 1);
    chk("t5_rst_byte", u_tx_byte, 8'h00);
    chk("t5_rst_utx", u_transmit, 0);
    chk("t5_rst_rxv", rx_valid, 0);
    chk("t5_rst_cnt", rx_count, 0);
    step(2);
    reset_n = 1'b1;
    step(100);
    chk("t5_no_more_tx", strobes - s0, 1);
    chk("t5_busy_after", tx_busy, 0);

`ifdef UART_FIFO_BRIDGE_ECHO_EN
    // 6: echo path
    s0   = strobes;
    echo = 1'b1;
    send_rx(8'h7E);
    tx_data  = 8'h33;
    tx_write = 1'b1;
    #1;
    chk("t6_ready_low", tx_ready, 0);
    step();
    tx_write = 1'b0;
    echo     = 1'b0;
    chk("t6_rx_data", rx_data, 8'h7E);
    wait_tx_idle(s0 + 1);
    step(20);
    chk("t6_strobes", strobes - s0, 1);
    chk("t6_echo_byte", tx_log.size() > 0 ? tx_log[tx_log.size()-1] : 8'hXX, 8'h7E);
    chk("t6_idle", tx_busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
